// File: rtl/cordic_sqrt_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined hyperbolic
// CORDIC square-root unit.
//
// Constants are stored once at 30 fractional bits. They are requantised to
// whatever fractional width an instance uses, with round-to-nearest.
//   inv_kh(fb)     : 1/K_h (about 1.2074970678) with fb fractional bits.
//                    This is the gain of the iteration set that repeats i=4 and i=13.
//   a_min(frac)    : lowest operand inside the convergence domain (0.03).
//   quarter(fb)    : 0.25 with fb fractional bits.
//   shift_of(k)    : iteration index i used by pipeline stage k (k >= 1).
//   num_stages(it) : number of iteration stages for highest index it.
package cordic_sqrt_pkg;

    localparam longint INV_KH_Q30 = 64'sd1296540104;  // 1.2074970678 * 2^30
    localparam longint A_MIN_Q30  = 64'sd32212255;    // 0.03 * 2^30

    function automatic longint requant(input longint q30, input int fb);
        if (fb >= 30)
            return q30 <<< (fb - 30);
        return (q30 + (64'sd1 <<< (29 - fb))) >>> (30 - fb);
    endfunction

    function automatic longint inv_kh(input int fb);
        return requant(INV_KH_Q30, fb);
    endfunction

    function automatic longint a_min(input int frac);
        return requant(A_MIN_Q30, frac);
    endfunction

    function automatic longint quarter(input int fb);
        return 64'sd1 <<< (fb - 2);
    endfunction

    // The stage sequence is i = 1,2,3,4,4,5,...,13,13,14,...
    // Every stage after the first repeat lags k by one.
    // Every stage after the second repeat lags k by two.
    function automatic int shift_of(input int k);
        if (k >= 15)
            return k - 2;
        if (k >= 5)
            return k - 1;
        return k;
    endfunction

    // ITERS is at least 4, so the i=4 repeat is always present.
    function automatic int num_stages(input int iters);
        return iters + 1 + ((iters >= 13) ? 1 : 0);
    endfunction

endpackage

// File: rtl/cordic_sqrt_stage.sv
// One registered hyperbolic-vectoring CORDIC iteration.
// The rotation direction drives y toward zero.
//   clk, reset (async, active-high), en (hold when low)
//   x, y : signed stage inputs        -> xo, yo : registered results
//   v    : valid tag                  -> vo     : registered, unchanged
//   oor  : out-of-domain tag          -> ooro   : registered, unchanged
module cordic_hyp_stage #(
    parameter int IW    = 26,
    parameter int SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic                 v,
    input  logic                 oor,
    output logic signed [IW-1:0] xo,
    output logic signed [IW-1:0] yo,
    output logic                 vo,
    output logic                 ooro
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    assign x_sh = x >>> SHIFT;
    assign y_sh = y >>> SHIFT;

    // NOTE: non-blocking assignments let both updates see the pre-stage x and y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xo   <= '0;
            yo   <= '0;
            vo   <= 1'b0;
            ooro <= 1'b0;
        end else if (en) begin
            if (!y[IW-1]) begin
                xo <= x - y_sh;
                yo <= y - x_sh;
            end else begin
                xo <= x + y_sh;
                yo <= y + x_sh;
            end
            vo   <= v;
            ooro <= oor;
        end
    end

endmodule

// File: rtl/cordic_sqrt_pipe.sv
// Fully pipelined hyperbolic-vectoring CORDIC square root.
// Starting from x0 = a + 1/4 and y0 = a - 1/4, vectoring drives y to zero.
// The final x is then K_h * sqrt(a). A last multiply by 1/K_h removes that gain.
// Latency is num_stages(ITERS) + 2 enabled cycles. Throughput is one operand per
// enabled cycle. ITERS must be within 4..30 and GUARD must be at least 1.
//   clk, reset (async, active-high), en (freezes the whole pipe when low)
//   in_valid, in_data   : operand a, unsigned, FRAC fractional bits
//   out_valid, out_data : sqrt(a), unsigned, FRAC fractional bits
//   out_oor             : a was outside [0.03, 2.0); out_data is meaningless
module cordic_sqrt_pipe
    import cordic_sqrt_pkg::*;
#(
    parameter int W     = 22,
    parameter int FRAC  = 20,
    parameter int ITERS = 16,
    parameter int GUARD = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_oor
);

    localparam int IW   = W + GUARD + 2;  // sign bit plus headroom for x0 up to 4.25
    localparam int FB   = FRAC + GUARD;
    localparam int S    = num_stages(ITERS);
    localparam int KW   = FB + 2;
    localparam int HALF = (GUARD > 0) ? (1 << (GUARD - 1)) : 0;

    localparam logic signed [IW-1:0] QTR   = IW'(quarter(FB));
    localparam logic signed [IW-1:0] TWO_I = IW'(64'd1 << (FB + 1));
    localparam logic [W-1:0]         AMIN  = W'(a_min(FRAC));
    localparam logic signed [KW-1:0] KH    = KW'(inv_kh(FB));

    // Stage 0: form x0/y0 and classify the operand.
    logic signed [IW-1:0] a_ext;
    logic signed [IW-1:0] x0;
    logic signed [IW-1:0] y0;
    logic                 v0;
    logic                 oor0;

    assign a_ext = IW'(in_data) << GUARD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0   <= '0;
            y0   <= '0;
            v0   <= 1'b0;
            oor0 <= 1'b0;
        end else if (en) begin
            x0   <= a_ext + QTR;
            y0   <= a_ext - QTR;
            v0   <= in_valid;
            oor0 <= (in_data < AMIN) || (a_ext >= TWO_I);
        end
    end

    // Iteration stages 1..S.
    logic signed [IW-1:0] xp   [1:S];
    logic signed [IW-1:0] yp   [1:S];
    logic                 vp   [1:S];
    logic                 oorp [1:S];

    for (genvar k = 1; k <= S; k++) begin : g_stage
        logic signed [IW-1:0] xi;
        logic signed [IW-1:0] yi;
        logic                 vi;
        logic                 oi;

        if (k == 1) begin : g_first
            assign xi = x0;
            assign yi = y0;
            assign vi = v0;
            assign oi = oor0;
        end else begin : g_next
            assign xi = xp[k-1];
            assign yi = yp[k-1];
            assign vi = vp[k-1];
            assign oi = oorp[k-1];
        end

        cordic_hyp_stage #(
            .IW   (IW),
            .SHIFT(shift_of(k))
        ) u_stage (
            .clk (clk),
            .reset(reset),
            .en  (en),
            .x   (xi),
            .y   (yi),
            .v   (vi),
            .oor (oi),
            .xo  (xp[k]),
            .yo  (yp[k]),
            .vo  (vp[k]),
            .ooro(oorp[k])
        );
    end

    // Gain compensation and output formatting.
    logic signed [IW+KW-1:0] prod;
    logic signed [IW-1:0]    xg;
    logic signed [IW:0]      rnd;
    logic signed [IW:0]      rsh;
    logic [W-1:0]            sat;

    assign prod = (IW+KW)'(xp[S]) * (IW+KW)'(KH);
    assign xg   = IW'(prod >>> FB);
    assign rnd  = {xg[IW-1], xg} + (IW+1)'(HALF);  // one extra bit so +HALF cannot wrap
    assign rsh  = rnd >>> GUARD;

    // NOTE: sat gets its default first so no path through this block can infer a latch.
    always_comb begin
        sat = rsh[W-1:0];
        if (rsh[IW])
            sat = '0;             // negative x only arises for out-of-domain operands
        else if (|rsh[IW-1:W])
            sat = '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_oor   <= 1'b0;
        end else if (en) begin
            out_valid <= vp[S];
            out_data  <= sat;
            out_oor   <= oorp[S];
        end
    end

endmodule
